// File: rtl/fetch_unit.sv
// VR16 instruction fetch: PC, instruction memory request, jump handshake.
// Optional: FETCH_STALL_COUNTER_EN enables the memory wait-cycle counter.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_pc_increment,
  input  logic        enable_jump,
  input  logic [15:0] jump_address,
  output logic        jump_done,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] pc_out,
  output logic [15:0] instruction_out,
  output logic        instruction_valid,
  output logic [15:0] stall_cycles
);

  localparam logic [0:0] S_REQUEST = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  logic [0:0]  state;
  logic [15:0] pc;
  logic        jump_accept;
  logic        pc_change;

  // a held enable_jump during the acknowledge cycle must not re-trigger
  assign jump_accept = enable_jump && !jump_done;
  assign pc_change   = jump_accept || enable_pc_increment;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      instruction_out <= 16'h0000;
      jump_done       <= 1'b0;
      state           <= S_REQUEST;
    end else begin
      jump_done <= jump_accept;
      if (pc_change) begin
        pc    <= jump_accept ? jump_address : pc + 16'd1;
        state <= S_REQUEST;
      end else if (state == S_REQUEST && imem_valid) begin
        instruction_out <= imem_data;
        state           <= S_HOLD;
      end
    end
  end

  assign imem_read         = (state == S_REQUEST) && !reset;
  assign imem_address      = pc;
  assign pc_out            = pc;
  assign instruction_valid = (state == S_HOLD);

`ifdef FETCH_STALL_COUNTER_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
    end else if (state == S_REQUEST && !imem_valid
                 && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus wait-state,
// stale-response and reset-during-jump sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable_pc_increment = 1'b0;
  logic        enable_jump = 1'b0;
  logic [15:0] jump_address = 16'h0000;
  logic        jump_done;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [15:0] pc_out;
  logic [15:0] instruction_out;
  logic        instruction_valid;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  int          wait_states = 0;
  logic        stale_inject = 1'b0;
  int          acc = 0;
  logic [15:0] acc_addr = 16'h0000;
  int          eff;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0010)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pc_increment(enable_pc_increment),
    .enable_jump        (enable_jump),
    .jump_address       (jump_address),
    .jump_done          (jump_done),
    .imem_read          (imem_read),
    .imem_address       (imem_address),
    .imem_data          (imem_data),
    .imem_valid         (imem_valid),
    .pc_out             (pc_out),
    .instruction_out    (instruction_out),
    .instruction_valid  (instruction_valid),
    .stall_cycles       (stall_cycles)
  );

  function automatic logic [15:0] word(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h3C3C);
  endfunction

  // memory model: answers after wait_states cycles at a stable address
  always_comb begin
    eff = (acc_addr == imem_address) ? acc : 0;
    imem_valid = stale_inject || (imem_read && eff >= wait_states);
    imem_data = stale_inject ? 16'hDEAD : word(imem_address);
  end

  always @(posedge clk) begin
    if (imem_read && !imem_valid) begin
      acc      <= eff + 1;
      acc_addr <= imem_address;
    end else begin
      acc <= 0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        inc;
    logic        jmp;
    logic [15:0] ja;
    logic [15:0] pc;
    logic        vld;
    logic        jd;
    logic [15:0] ins;
  } vec_t;

  vec_t v[12];
  logic [15:0] exp_stall;

  initial begin
    v[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0011, 1'b0, 1'b0, 16'hA5A5};
    v[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0011, 1'b1, 1'b0, word(16'h0011)};
    v[2]  = '{1'b0, 1'b1, 16'h0040, 16'h0040, 1'b0, 1'b1, word(16'h0011)};
    v[3]  = '{1'b0, 1'b1, 16'h0040, 16'h0040, 1'b1, 1'b0, word(16'h0040)};
    v[4]  = '{1'b0, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b1, word(16'h0040)};
    v[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0005, 1'b1, 1'b0, word(16'h0005)};
    v[6]  = '{1'b1, 1'b1, 16'h0100, 16'h0100, 1'b0, 1'b1, word(16'h0005)};
    v[7]  = '{1'b0, 1'b0, 16'h0000, 16'h0100, 1'b1, 1'b0, word(16'h0100)};
    v[8]  = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, word(16'h0100)};
    v[9]  = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, word(16'hFFFF)};
    v[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, word(16'hFFFF)};
    v[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, word(16'h0000)};
`ifdef FETCH_STALL_COUNTER_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif

    step();
    step();
    chk("rst_pc", pc_out, 16'h0010);
    chk("rst_ins", instruction_out, 16'h0000);
    chk("rst_vld", {15'b0, instruction_valid}, 16'd0);
    chk("rst_jd", {15'b0, jump_done}, 16'd0);
    chk("rst_read", {15'b0, imem_read}, 16'd0);
    chk("rst_stall", stall_cycles, 16'h0000);

    reset = 1'b0;
    #1;
    chk("first_read", {15'b0, imem_read}, 16'd1);
    chk("first_addr", imem_address, 16'h0010);
    step();
    chk("first_ins", instruction_out, 16'hA5A5);
    chk("first_vld", {15'b0, instruction_valid}, 16'd1);
    chk("first_hold", {15'b0, imem_read}, 16'd0);

    for (int i = 0; i < 12; i++) begin
      enable_pc_increment = v[i].inc;
      enable_jump = v[i].jmp;
      jump_address = v[i].ja;
      step();
      chk($sformatf("v%0d_pc", i), pc_out, v[i].pc);
      chk($sformatf("v%0d_addr", i), imem_address, v[i].pc);
      chk($sformatf("v%0d_vld", i), {15'b0, instruction_valid},
          {15'b0, v[i].vld});
      chk($sformatf("v%0d_read", i), {15'b0, imem_read},
          {15'b0, ~v[i].vld});
      chk($sformatf("v%0d_jd", i), {15'b0, jump_done}, {15'b0, v[i].jd});
      chk($sformatf("v%0d_ins", i), instruction_out, v[i].ins);
    end
    enable_pc_increment = 1'b0;
    enable_jump = 1'b0;
    chk("zw_stall", stall_cycles, 16'h0000);

    wait_states = 3;
    enable_pc_increment = 1'b1;
    step();
    enable_pc_increment = 1'b0;
    chk("ws_pc", pc_out, 16'h0001);
    chk("ws_read", {15'b0, imem_read}, 16'd1);
    step();
    step();
    chk("ws_wait", {15'b0, instruction_valid}, 16'd0);
    chk("ws_addr", imem_address, 16'h0001);
    enable_jump = 1'b1;
    jump_address = 16'h0200;
    stale_inject = 1'b1;
    step();
    enable_jump = 1'b0;
    stale_inject = 1'b0;
    chk("stale_pc", pc_out, 16'h0200);
    chk("stale_jd", {15'b0, jump_done}, 16'd1);
    chk("stale_vld", {15'b0, instruction_valid}, 16'd0);
    chk("stale_ins", instruction_out, word(16'h0000));
    step();
    chk("stale_jd_off", {15'b0, jump_done}, 16'd0);
    step();
    step();
    chk("ws3_vld", {15'b0, instruction_valid}, 16'd0);
    step();
    chk("ws3_vld_on", {15'b0, instruction_valid}, 16'd1);
    chk("ws3_ins", instruction_out, word(16'h0200));
    chk("ws3_stall", stall_cycles, exp_stall);

    wait_states = 0;
    enable_jump = 1'b1;
    jump_address = 16'h0300;
    reset = 1'b1;
    step();
    enable_jump = 1'b0;
    chk("rj_jd", {15'b0, jump_done}, 16'd0);
    chk("rj_pc", pc_out, 16'h0010);
    chk("rj_stall", stall_cycles, 16'h0000);
    chk("rj_ins", instruction_out, 16'h0000);
    chk("rj_read", {15'b0, imem_read}, 16'd0);
    reset = 1'b0;
    step();
    chk("rj_jd2", {15'b0, jump_done}, 16'd0);
    chk("rj_pc2", pc_out, 16'h0010);
    chk("rj_vld2", {15'b0, instruction_valid}, 16'd1);
    chk("rj_ins2", instruction_out, 16'hA5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the VR16 core, sitting directly upstream of the instruction decoder and control unit. Holds the program counter and reads 16-bit instruction words from instruction memory over a valid-qualified request interface. Presents the latched instruction to the decoder. Services the control unit's `enable_pc_increment` pulse and its `enable_jump`/`jump_done` handshake.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable_pc_increment`  in  1  one-cycle pulse from the control unit: advance the PC by 1.
- `enable_jump`  in  1  level from the control unit, held until `jump_done`.
- `jump_address`  in  16  jump target, sampled when a jump is accepted.
- `jump_done`  out  1  one-cycle pulse acknowledging the jump.
- `imem_read`  out  1  fetch request to instruction memory.
- `imem_address`  out  16  word address; always equals `pc_out`.
- `imem_data`  in  16  instruction word.
- `imem_valid`  in  1  `imem_data` is valid for the address presented in the same cycle; may assert in the same cycle as `imem_read`.
- `pc_out`  out  16  current program counter.
- `instruction_out`  out  16  last fetched instruction, to the decoder.
- `instruction_valid`  out  1  `instruction_out` corresponds to `pc_out`.
- `stall_cycles`  out  16  memory wait-cycle counter (see Configuration).

## Operation
- States: REQUEST (`imem_read`=1, waiting on memory) and HOLD (`imem_read`=0, `instruction_valid`=1).
- REQUEST with `imem_valid`=1 and no PC change this cycle: latch `imem_data` into `instruction_out`, set `instruction_valid`, and go to HOLD.
- PC change events (in any state): accepted jump, `pc = jump_address`; otherwise `enable_pc_increment`, `pc = pc + 1`.
- Any PC change clears `instruction_valid` and enters REQUEST on the next cycle.
- A memory response in the same cycle as a PC change is discarded. It belongs to the old address.
- Jump acceptance: `enable_jump`=1 and `jump_done`=0. `jump_done` is registered and asserts in the following cycle for exactly one cycle.
- `enable_jump` seen while `jump_done`=1 is ignored. This covers the control unit still holding it during the acknowledge cycle.
- A jump and an increment in the same cycle: the jump wins and the increment is dropped.
- PC arithmetic is 16-bit unsigned and wraps from 16'hFFFF to 16'h0000. Jump targets are taken verbatim.
- In HOLD, `instruction_out` is stable until the next latch.
- `instruction_out` is not cleared on a PC change; only `instruction_valid` drops.

## Timing
- Reset values: `pc_out`=`RESET_PC`, `instruction_out`=16'h0000, `instruction_valid`=0, `jump_done`=0, `stall_cycles`=0, state=REQUEST.
- `imem_read` is forced to 0 while `reset` is high. The first request goes out in the first cycle after `reset` deasserts.
- Reset mid-fetch or mid-jump aborts the operation. Any response in the reset cycle is dropped, and a pending `jump_done` is cancelled.
- Latency with zero-wait memory: PC update at edge E, then `imem_read` in cycle E..E+1, then `instruction_out` and `instruction_valid` valid from edge E+1. This meets the control unit's FETCH→DECODE spacing.
- Each memory wait cycle adds one cycle of latency.
- Jump: `enable_jump` sampled at edge E, then `pc_out` = target and `jump_done`=1 during cycle E..E+1. `jump_done` is 0 again from edge E+1. The new instruction is latched no earlier than edge E+1.
- `imem_address` changes only at clock edges. It is held stable while a request is outstanding unless the PC changes.

## Configuration
- Macro: `FETCH_STALL_COUNTER_EN`.
- Defined: `stall_cycles` increments by 1 for every cycle in REQUEST with `imem_valid`=0. It is cumulative since reset, saturates at 16'hFFFF, and is cleared only by `reset`.
- Not defined: `stall_cycles` is tied to 16'h0000 and no counter logic is synthesised. The port remains present.

## Test plan
- Reset with `RESET_PC`=16'h0010 and zero-wait memory returning 16'hA5A5 → `pc_out`=16'h0010; one cycle after reset `instruction_out`=16'hA5A5 and `instruction_valid`=1.
- `enable_pc_increment` pulse at PC 16'hFFFF → `pc_out`=16'h0000, `instruction_valid` low for one cycle, then the word at address 0 is latched.
- `enable_jump` held 2 cycles with `jump_address`=16'h0040 → PC=16'h0040 and `jump_done` high for exactly one cycle. No second jump is accepted.
- `enable_jump` and `enable_pc_increment` asserted together at PC 16'h0005 with target 16'h0100 → `pc_out`=16'h0100, not 16'h0006.
- Memory with 3 wait states, jump issued while a fetch is outstanding, stale `imem_valid` arriving in the jump cycle → stale data is not latched. The word from the new address is latched. With `FETCH_STALL_COUNTER_EN`, `stall_cycles` increases by the number of `imem_valid`=0 REQUEST cycles.
- `reset` asserted mid-jump (the cycle before `jump_done`) → `jump_done` never pulses, `pc_out`=`RESET_PC`, and `stall_cycles`=0.
